// File: rtl/sqrt_arbiter.sv
// Shares one iterative sqrt unit between NUM_REQ level requesters, with a WAIT-state watchdog.
// Define SQRT_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module sqrt_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_WAIT = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [32*NUM_REQ-1:0]      req_square,
  output logic [NUM_REQ-1:0]         done,
  output logic [31:0]                result,
  output logic                       err,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       active,
  output logic                       sq_calculate,
  output logic [31:0]                sq_square,
  input  logic [31:0]                sq_root,
  input  logic                       sq_busy,
  output logic [2:0]                 dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_WAIT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ARM   = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [31:0]        sq_square_q, sq_square_d;
  logic [31:0]        result_q, result_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]   winner;

`ifdef SQRT_ARB_RR_EN
  // rr_ptr_q is where the next search begins: one past the most recent grant.
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  always_comb begin
    logic found;
    int   idx;
    winner = rr_ptr_q;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == IDLE && (|req)) begin
      rr_ptr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) winner = IDX_W'(i);
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    sq_square_d = sq_square_q;
    result_d    = result_q;
    err_d       = err_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_idx_d = winner;
          sq_square_d = req_square[32*winner +: 32];
          state_d     = START;
        end
      end
      START: state_d = ARM;
      ARM: begin
        // The unit only raises busy a cycle after the start pulse, so busy is not trusted here.
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (!sq_busy) begin
          result_d = sq_root;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      sq_square_q <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      sq_square_q <= sq_square_d;
      result_q    <= result_d;
      err_q       <= err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Outputs are decoded from registered state only, so they are glitch-free and one cycle wide.
  always_comb begin
    done = '0;
    if (state_q == RESP) done[grant_idx_q] = 1'b1;
  end

  assign sq_calculate = (state_q == START);
  assign active       = (state_q != IDLE);
  assign grant_idx    = grant_idx_q;
  assign sq_square    = sq_square_q;
  assign result       = result_q;
  assign err          = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed + randomized bench for sqrt_arbiter with a 16-step sqrt unit stub and an arithmetic reference model.
module tb_sqrt_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int MAX_WAIT = 32;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]    req = '0;
  logic [32*NUM_REQ-1:0] req_square = '0;
  logic [NUM_REQ-1:0]    done;
  logic [31:0]           result;
  logic                  err;
  logic [1:0]            grant_idx;
  logic                  active;
  logic                  sq_calculate;
  logic [31:0]           sq_square;
  logic [31:0]           sq_root;
  logic                  sq_busy;
  logic [2:0]            dbg_state;

  sqrt_arbiter #(.NUM_REQ(NUM_REQ), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_square(req_square),
    .done(done), .result(result), .err(err), .grant_idx(grant_idx),
    .active(active), .sq_calculate(sq_calculate), .sq_square(sq_square),
    .sq_root(sq_root), .sq_busy(sq_busy), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int rr_next = 0;

  function automatic logic [31:0] isqrt(input logic [31:0] v);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= longint'(v)) lo = mid;
      else hi = mid;
    end
    return lo[31:0];
  endfunction

  // Iterative unit stub: busy for 16 cycles after the start pulse, root garbage while busy.
  int          busy_cnt = 0;
  logic        hang = 1'b0;
  logic [31:0] root_q = '0;
  always @(posedge clk) begin
    if (!resetn) begin
      busy_cnt <= 0;
      root_q   <= '0;
    end else if (sq_calculate) begin
      busy_cnt <= 16;
      root_q   <= isqrt(sq_square);
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign sq_busy = hang || (busy_cnt != 0);
  assign sq_root = sq_busy ? 32'hDEAD_BEEF : root_q;

  // Reference arbitration: pick the winner among pending requesters.
  function automatic int pick(input logic [NUM_REQ-1:0] m, input int start);
`ifdef SQRT_ARB_RR_EN
    for (int k = 0; k < NUM_REQ; k++) if (m[(start + k) % NUM_REQ]) return (start + k) % NUM_REQ;
`else
    for (int i = 0; i < NUM_REQ; i++) if (m[i]) return i;
`endif
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; counts negedges until done is seen (bounded).
  task automatic wait_done(output int lat, output logic [NUM_REQ-1:0] d, output int calcs,
                           output logic [31:0] sq_seen, output bit sq_ok);
    lat = 0; d = '0; calcs = 0; sq_seen = '0; sq_ok = 1'b1;
    while (d == '0 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (sq_calculate) calcs++;
      if (lat == 1) sq_seen = sq_square;
      else if (active && sq_square !== sq_seen) sq_ok = 1'b0;
      d = done;
    end
  endtask

  task automatic do_op(input int idx, input logic [31:0] opnd, input int exp_lat, input bit exp_err);
    int lat, calcs, w;
    logic [NUM_REQ-1:0] d;
    logic [31:0] sq_seen;
    bit sq_ok;
    @(negedge clk);
    req_square[32*idx +: 32] = opnd;
    req[idx] = 1'b1;
    w = pick(req, rr_next);
    rr_next = (w + 1) % NUM_REQ;
    wait_done(lat, d, calcs, sq_seen, sq_ok);
    req[idx] = 1'b0;
    check("latency", lat, exp_lat);
    check("done", d, 64'(1) << w);
    check("grant_idx", grant_idx, w);
    check("result", result, exp_err ? 32'd0 : isqrt(opnd));
    check("err", err, exp_err);
    check("calc_pulses", calcs, 1);
    check("sq_square", sq_seen, opnd);
    check("sq_stable", sq_ok, 1);
  endtask

  initial begin
    int lat, calcs, w, seen;
    logic [NUM_REQ-1:0] d, remaining;
    logic [31:0] sq_seen, ops[4];
    bit sq_ok;
    logic [31:0] bounds[4];
    bounds[0] = 32'd0; bounds[1] = 32'd1; bounds[2] = 32'hFFFF_FFFF; bounds[3] = 32'h4000_0000;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    check("rst_grant", grant_idx, 0);
    check("rst_sq_square", sq_square, 0);
    check("rst_active", active, 0);
    check("rst_calc", sq_calculate, 0);
    resetn = 1'b1;

    // single request, 144 -> 12, then result held
    do_op(0, 32'd144, 19, 1'b0);
    repeat (3) @(negedge clk);
    check("held_result", result, 12);
    check("held_done", done, 0);

    // boundary operands then random operands on random requesters
    for (int i = 0; i < 4; i++) do_op(i, bounds[i], 19, 1'b0);
    check("held_between", result, 32768);
    for (int i = 0; i < 4; i++) do_op($urandom_range(0, NUM_REQ - 1), $urandom, 19, 1'b0);

    // all requesters held high continuously
    @(negedge clk);
    ops[0] = 4; ops[1] = 9; ops[2] = 16; ops[3] = 25;
    for (int i = 0; i < NUM_REQ; i++) req_square[32*i +: 32] = ops[i];
    req = '1;
    for (int p = 0; p < 8; p++) begin
      wait_done(lat, d, calcs, sq_seen, sq_ok);
      w = pick(req, rr_next);
      rr_next = (w + 1) % NUM_REQ;
      check("all_lat", lat, (p == 0) ? 19 : 20);
      check("all_done", d, 64'(1) << w);
      check("all_result", result, isqrt(ops[w]));
    end
    req = '0;

    // random request masks, each requester drops after its own done
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        ops[i] = $urandom;
        req_square[32*i +: 32] = ops[i];
      end
      remaining = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      req = remaining;
      for (int p = 0; remaining != '0 && p < NUM_REQ; p++) begin
        wait_done(lat, d, calcs, sq_seen, sq_ok);
        w = pick(remaining, rr_next);
        rr_next = (w + 1) % NUM_REQ;
        check("rnd_lat", lat, (p == 0) ? 19 : 20);
        check("rnd_done", d, 64'(1) << w);
        check("rnd_result", result, isqrt(ops[w]));
        check("rnd_err", err, 0);
        remaining[w] = 1'b0;
        req[w] = 1'b0;
      end
    end

    // timeout with a hung unit, then recovery
    hang = 1'b1;
    do_op(0, 32'd49, 3 + MAX_WAIT, 1'b1);
    repeat (2) @(negedge clk);
    check("err_stable", err, 1);
    check("err_result_stable", result, 0);
    hang = 1'b0;
    do_op(0, 32'd49, 19, 1'b0);

    // reset during WAIT
    @(negedge clk);
    req_square[32*1 +: 32] = 32'd81;
    req[1] = 1'b1;
    repeat (8) @(negedge clk);
    check("pre_rst_active", active, 1);
    resetn = 1'b0;
    req = '0;
    @(negedge clk);
    rr_next = 0;
    resetn = 1'b1;
    check("mid_rst_active", active, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_grant", grant_idx, 0);
    check("mid_rst_sq_square", sq_square, 0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done != '0) seen++;
    end
    check("no_done_after_rst", seen, 0);
    do_op(3, 32'd1234567, 19, 1'b0);

    // served requester drops req during WAIT; pending requester granted right after RESP
    @(negedge clk);
    req_square[0 +: 32] = 32'd100;
    req_square[64 +: 32] = 32'd49;
    req[0] = 1'b1;
    w = pick(req, rr_next);
    rr_next = (w + 1) % NUM_REQ;
    lat = 0;
    d = '0;
    while (d == '0 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 2) req[2] = 1'b1;
      if (lat == 8) req[0] = 1'b0;
      d = done;
    end
    check("drop_lat", lat, 19);
    check("drop_done", d, 64'(1) << w);
    check("drop_result", result, 10);
    w = pick(req, rr_next);
    rr_next = (w + 1) % NUM_REQ;
    @(negedge clk);
    check("drop_idle", active, 0);
    @(negedge clk);
    check("next_calc", sq_calculate, 1);
    check("next_grant", grant_idx, w);
    wait_done(lat, d, calcs, sq_seen, sq_ok);
    req[2] = 1'b0;
    check("next_lat", lat, 18);
    check("next_done", d, 64'(1) << w);
    check("next_result", result, 7);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
